// File: rtl/addr_reg_file_stack.sv
// Address register file: NREGS registers, the top one a bounds-checked stack pointer with sticky flags.
// Optional macro ARF_WRITE_BYPASS_EN: loads are visible on the read ports in the same cycle.
module addr_reg_file_stack #(
  parameter int               WIDTH     = 16,
  parameter int               NREGS     = 4,
  parameter logic [WIDTH-1:0] SP_TOP    = WIDTH'(16'h00FF),
  parameter logic [WIDTH-1:0] SP_BOTTOM = WIDTH'(16'h00F0),
  parameter int               SELW      = $clog2(NREGS)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [NREGS-1:0] RegSel,
  input  logic             Push,
  input  logic             Pop,
  input  logic             ClrFlags,
  input  logic [SELW-1:0]  OutCSel,
  input  logic [SELW-1:0]  OutDSel,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int SPIDX = NREGS - 1;
  localparam int NSEL  = 2 ** SELW;

  logic [WIDTH-1:0] regFile  [NREGS];
  logic [WIDTH-1:0] regNext  [NREGS-1];
  logic [WIDTH-1:0] readVals [NSEL];
  logic [WIDTH-1:0] spCur;
  logic [WIDTH-1:0] spNext;
  logic             overflowReg;
  logic             underflowReg;
  logic             overflowNext;
  logic             underflowNext;
  logic             pushOnly;
  logic             popOnly;

  function automatic logic [WIDTH-1:0] applyFun(input logic [2:0] fs,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] din);
    case (fs)
      3'b001:  applyFun = '0;
      3'b010:  applyFun = din;
      3'b011:  applyFun = cur + WIDTH'(1);
      3'b100:  applyFun = cur - WIDTH'(1);
      3'b101:  applyFun = WIDTH'(din[7:0]);
      default: applyFun = cur;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < SPIDX; gi++) begin : gen_gp_next
      assign regNext[gi] = RegSel[gi] ? regFile[gi] : applyFun(FunSel, regFile[gi], I);
    end
  endgenerate

  assign spCur    = regFile[SPIDX];
  assign pushOnly = Push & ~Pop;
  assign popOnly  = Pop & ~Push;

  // Any stack request (even Push+Pop cancelling out) takes SP away from FunSel.
  always_comb begin
    spNext        = spCur;
    overflowNext  = overflowReg & ~ClrFlags;
    underflowNext = underflowReg & ~ClrFlags;
    if (pushOnly) begin
      if (spCur == SP_BOTTOM) overflowNext = 1'b1;
      else                    spNext = spCur - WIDTH'(1);
    end else if (popOnly) begin
      if (spCur == SP_TOP) underflowNext = 1'b1;
      else                 spNext = spCur + WIDTH'(1);
    end else if (!Push && !Pop && !RegSel[SPIDX]) begin
      spNext = applyFun(FunSel, spCur, I);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int k = 0; k < SPIDX; k++) regFile[k] <= '0;
      regFile[SPIDX] <= SP_TOP;
      overflowReg    <= 1'b0;
      underflowReg   <= 1'b0;
    end else begin
      for (int k = 0; k < SPIDX; k++) regFile[k] <= regNext[k];
      regFile[SPIDX] <= spNext;
      overflowReg    <= overflowNext;
      underflowReg   <= underflowNext;
    end
  end

`ifdef ARF_WRITE_BYPASS_EN
  logic [NREGS-1:0] loadEn;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : gen_load_en
      assign loadEn[gi] = (FunSel == 3'b010) && !RegSel[gi] && ((gi != SPIDX) || !(Push || Pop));
    end
  endgenerate
`endif

  // Read table padded to the full select range; unused selects read as zero.
  generate
    for (gi = 0; gi < NSEL; gi++) begin : gen_read
      if (gi < NREGS) begin : gen_live
`ifdef ARF_WRITE_BYPASS_EN
        assign readVals[gi] = loadEn[gi] ? I : regFile[gi];
`else
        assign readVals[gi] = regFile[gi];
`endif
      end else begin : gen_pad
        assign readVals[gi] = '0;
      end
    end
  endgenerate

  assign OutC      = readVals[OutCSel];
  assign OutD      = readVals[OutDSel];
  assign Overflow  = overflowReg;
  assign Underflow = underflowReg;

endmodule

// File: tb/tb_addr_reg_file_stack.sv
// Scoreboard bench for addr_reg_file_stack: a reference model queues expected reads per cycle.
module tb_addr_reg_file_stack;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] I = '0;
  logic [2:0]  FunSel = '0;
  logic [3:0]  RegSel = 4'hF;
  logic        Push = 1'b0;
  logic        Pop = 1'b0;
  logic        ClrFlags = 1'b0;
  logic [1:0]  OutCSel = '0;
  logic [1:0]  OutDSel = '0;
  logic [15:0] OutC;
  logic [15:0] OutD;
  logic        Overflow;
  logic        Underflow;

  addr_reg_file_stack dut (
    .Clock(Clock), .Reset_n(Reset_n), .I(I), .FunSel(FunSel), .RegSel(RegSel),
    .Push(Push), .Pop(Pop), .ClrFlags(ClrFlags), .OutCSel(OutCSel), .OutDSel(OutDSel),
    .OutC(OutC), .OutD(OutD), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       tag;
    logic [1:0]  cs;
    logic [1:0]  ds;
    logic [15:0] c;
    logic [15:0] d;
    logic        ov;
    logic        un;
  } expT;

  expT         sbQ[$];
  logic [15:0] m[4];
  logic        mOv = 1'b0;
  logic        mUn = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] funModel(input logic [2:0] fs, input logic [15:0] cur,
                                           input logic [15:0] din);
    case (fs)
      3'b001:  return 16'h0000;
      3'b010:  return din;
      3'b011:  return cur + 16'd1;
      3'b100:  return cur - 16'd1;
      3'b101:  return {8'h00, din[7:0]};
      default: return cur;
    endcase
  endfunction

  task automatic cycle(input string tag, input logic rstn, input logic [2:0] fs,
                       input logic [3:0] rs, input logic push, input logic pop,
                       input logic clr, input logic [15:0] din,
                       input logic [1:0] cs, input logic [1:0] ds);
    expT         e;
    logic [15:0] pre;
    logic        setOv;
    logic        setUn;
    Reset_n = rstn; FunSel = fs; RegSel = rs; Push = push; Pop = pop;
    ClrFlags = clr; I = din; OutCSel = cs; OutDSel = ds;
    #1;
    if (rstn) begin
      pre = m[cs];
`ifdef ARF_WRITE_BYPASS_EN
      if (fs == 3'b010 && !rs[cs] && (cs != 2'd3 || !(push || pop))) pre = din;
`endif
      checkVal({tag, "/preC"}, OutC, pre);
    end
    // reference model of the coming edge
    if (!rstn) begin
      m[0] = 16'h0000; m[1] = 16'h0000; m[2] = 16'h0000; m[3] = 16'h00FF;
      mOv = 1'b0; mUn = 1'b0;
    end else begin
      setOv = 1'b0; setUn = 1'b0;
      for (int k = 0; k < 3; k++) if (!rs[k]) m[k] = funModel(fs, m[k], din);
      if (push && !pop) begin
        if (m[3] == 16'h00F0) setOv = 1'b1; else m[3] = m[3] - 16'd1;
      end else if (pop && !push) begin
        if (m[3] == 16'h00FF) setUn = 1'b1; else m[3] = m[3] + 16'd1;
      end else if (!push && !pop && !rs[3]) begin
        m[3] = funModel(fs, m[3], din);
      end
      mOv = setOv | (mOv & ~clr);
      mUn = setUn | (mUn & ~clr);
    end
    e.tag = tag; e.cs = cs; e.ds = ds; e.c = m[cs]; e.d = m[ds]; e.ov = mOv; e.un = mUn;
    sbQ.push_back(e);
    @(posedge Clock);
    #1;
    Push = 1'b0; Pop = 1'b0; ClrFlags = 1'b0; FunSel = 3'b000; RegSel = 4'hF;
    #1;
    if (sbQ.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sbQ.pop_front();
      checkVal({e.tag, "/C"}, OutC, e.c);
      checkVal({e.tag, "/D"}, OutD, e.d);
      checkVal({e.tag, "/ov"}, {15'b0, Overflow}, {15'b0, e.ov});
      checkVal({e.tag, "/un"}, {15'b0, Underflow}, {15'b0, e.un});
      $display("cyc %-10s C[%0d]=%h D[%0d]=%h ov=%b un=%b", e.tag, e.cs, OutC, e.ds, OutD,
               Overflow, Underflow);
    end
  endtask

  initial begin
    m[0] = '0; m[1] = '0; m[2] = '0; m[3] = 16'h00FF;
    // reset overrides a simultaneous load and push
    cycle("reset",   1'b0, 3'b010, 4'b0000, 1'b1, 1'b0, 1'b0, 16'h1234, 2'd0, 2'd3);
    cycle("rd01",    1'b1, 3'b000, 4'b1111, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd1);
    cycle("rd23",    1'b1, 3'b000, 4'b1111, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 2'd3);
    cycle("ldFFFF",  1'b1, 3'b010, 4'b1110, 1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd0, 2'd1);
    cycle("incwrap", 1'b1, 3'b011, 4'b1110, 1'b0, 1'b0, 1'b0, 16'h5555, 2'd0, 2'd3);
    cycle("decwrap", 1'b1, 3'b100, 4'b1101, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 2'd0);
    cycle("ldlow",   1'b1, 3'b101, 4'b1011, 1'b0, 1'b0, 1'b0, 16'hABCD, 2'd2, 2'd1);
    cycle("hold110", 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0, 1'b0, 16'h7777, 2'd2, 2'd3);
    cycle("clr001",  1'b1, 3'b001, 4'b1101, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 2'd2);
    for (int n = 0; n < 15; n++)
      cycle("push", 1'b1, 3'b000, 4'b1111, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd3, 2'd0);
    cycle("push16",  1'b1, 3'b000, 4'b1111, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd3, 2'd0);
    cycle("pushclr", 1'b1, 3'b000, 4'b1111, 1'b1, 1'b0, 1'b1, 16'h0000, 2'd3, 2'd0);
    cycle("clrflag", 1'b1, 3'b000, 4'b1111, 1'b0, 1'b0, 1'b1, 16'h0000, 2'd3, 2'd0);
    cycle("reset2",  1'b0, 3'b000, 4'b1111, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 2'd0);
    cycle("popTop",  1'b1, 3'b000, 4'b1111, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 2'd0);
    cycle("pushpop", 1'b1, 3'b001, 4'b0111, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd3, 2'd0);
    cycle("pushld",  1'b1, 3'b010, 4'b0110, 1'b1, 1'b0, 1'b0, 16'h1234, 2'd0, 2'd3);
    cycle("bypass",  1'b1, 3'b010, 4'b1101, 1'b0, 1'b0, 1'b0, 16'hABCD, 2'd1, 2'd0);
    // SP moved outside the legal window by a load, then pushed without a flag
    cycle("spload",  1'b1, 3'b010, 4'b0111, 1'b0, 1'b0, 1'b1, 16'h0100, 2'd3, 2'd1);
    cycle("spoor",   1'b1, 3'b000, 4'b1111, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd3, 2'd1);
    cycle("spoorpop",1'b1, 3'b000, 4'b1111, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 2'd1);
    cycle("reset3",  1'b0, 3'b000, 4'b1111, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 2'd0);
    for (int n = 0; n < 40; n++)
      cycle("rand", 1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom),
            2'($urandom), 2'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_reg_file_stack.md
Name: addr_reg_file_stack

Overview:
- Parametrised address register file with NREGS registers of WIDTH bits, a shared per-cycle function select, and two independent combinational read ports (OutC, OutD).
- Register index NREGS-1 is a hardware stack pointer with Push/Pop, bounds checking and sticky Overflow/Underflow flags.
- Sits between the instruction/data path and the memory address mux; it is the multi-register, stack-aware successor of the 3-register PC/AR/SP file.

Parameters:
- WIDTH, 16, bit width of every register and of I/OutC/OutD.
- NREGS, 4, number of registers (min 2). Index 0 is PC, index NREGS-1 is SP.
- SP_TOP, 16'h00FF, SP reset value and highest legal SP (stack empty).
- SP_BOTTOM, 16'h00F0, lowest legal SP (stack full). Requires SP_BOTTOM < SP_TOP.
- SELW, $clog2(NREGS), read-select width (derived; do not override).

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- I  in  WIDTH  load data.
- FunSel  in  3  operation applied to every enabled register.
- RegSel  in  NREGS  per-register enable, active-low: bit k=0 enables register k.
- Push  in  1  SP <= SP-1 with bound check.
- Pop  in  1  SP <= SP+1 with bound check.
- ClrFlags  in  1  clears Overflow/Underflow.
- OutCSel  in  SELW  read select, port C.
- OutDSel  in  SELW  read select, port D.
- OutC  out  WIDTH  register[OutCSel], combinational.
- OutD  out  WIDTH  register[OutDSel], combinational.
- Overflow  out  1  sticky: Push attempted at SP_BOTTOM.
- Underflow  out  1  sticky: Pop attempted at SP_TOP.

Behaviour:
- Reset (Reset_n=0 at a rising edge): regs 0..NREGS-2 <= 0, SP <= SP_TOP, Overflow=Underflow=0. Reset overrides every other input, including a Push/Pop or load in the same cycle.
- FunSel codes, applied at the edge to each register k with RegSel[k]=0:
  - 000 hold
  - 001 clear to 0
  - 010 load I
  - 011 increment, wraps modulo 2^WIDTH
  - 100 decrement, wraps modulo 2^WIDTH
  - 101 load {zeros, I[7:0]}
  - 110 and 111 hold
- Registers with RegSel[k]=1 hold.
- Read latency: OutC/OutD are combinational from register state, so a write becomes visible on the cycle after its edge. Out-of-range selects (NREGS not a power of 2) return 0.
- SP priority: if Push XOR Pop is asserted, the stack operation owns SP that cycle and FunSel/RegSel for SP are ignored.
- Push: if SP==SP_BOTTOM, SP holds and Overflow<=1; else SP<=SP-1.
- Pop: if SP==SP_TOP, SP holds and Underflow<=1; else SP<=SP+1.
- Push and Pop together: SP is unchanged and no flag is set. FunSel on SP is also ignored that cycle.
- Flags are sticky until ClrFlags=1 or reset. A ClrFlags in the same cycle as a new fault leaves the flag set (set wins).
- FunSel writes to SP are unchecked: loads/inc/dec may move SP outside [SP_BOTTOM,SP_TOP]. A subsequent Push/Pop compares for equality only, so an out-of-range SP moves without a flag.
- Registers 0..NREGS-2 are unaffected by Push/Pop.

Optional Feature:
- Macro: ARF_WRITE_BYPASS_EN.
- Defined: when FunSel=010 and RegSel[k]=0 this cycle, a read port selecting k returns I combinationally (write-through), so latency is 0 for loads. Other FunSel codes and Push/Pop are not bypassed.
- Undefined: reads always return registered state (latency 1). No other difference.

Test Plan:
- Reset then read all: Reset_n=0 for 1 cycle -> OutC/OutD select 0..2 give 16'h0000, select 3 gives 16'h00FF, flags 0.
- Load/inc wrap: FunSel=010, RegSel=4'b1110, I=16'hFFFF, then FunSel=011 -> reg0 reads 16'hFFFF, then 16'h0000; regs 1..3 unchanged.
- Stack fill: 15 Pushes from reset -> SP=16'h00F0, Overflow=0; 16th Push -> SP stays 16'h00F0, Overflow=1; ClrFlags -> Overflow=0.
- Underflow and simultaneous ops: Pop at reset -> SP=16'h00FF, Underflow=1; Push+Pop with FunSel=001, RegSel=4'b0111 -> SP unchanged, no new flag.
- Push with FunSel on SP: Push=1, FunSel=010, I=16'h1234, RegSel=4'b0110 -> reg0=16'h1234, SP=16'h00FE.
- Bypass (macro defined): FunSel=010, RegSel=4'b1101, I=16'hABCD, OutCSel=1 -> OutC=16'hABCD in the same cycle. Macro undefined -> OutC shows the old value until the next cycle.
